// File: rtl/otf_csd2bin_if.sv
// Digit-in / word-out handshake bundle for otf_csd2bin.
// Slave is the converter's view; master is the upstream/downstream side.
interface otf_csd2bin_if #(parameter int W = 4);
  logic       in_vld;
  logic       in_rdy;
  logic [1:0] d;
  logic       out_vld;
  logic       out_rdy;
  logic [W:0] y;

  modport master (output in_vld, d, out_rdy, input in_rdy, out_vld, y);
  modport slave  (input in_vld, d, out_rdy, output in_rdy, out_vld, y);
endinterface

// File: rtl/otf_csd2bin.sv
// On-the-fly CSD (MSB-first) to two's-complement converter, W digits -> W+1 bit word.
// Optional sticky illegal-digit flag enabled by defining OTF_CSD2BIN_ERR_EN.
module otf_csd2bin #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  otf_csd2bin_if.slave bus,
  output logic         busy,
  output logic         err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [W:0] ONE = (W + 1)'(1);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W:0]    q;
  logic [W:0]    qm;
  logic [W:0]    y_q;
  logic          out_vld_q;

  logic          in_rdy;
  logic          take;
  logic          pos;
  logic          neg;
  logic [W:0]    bq;
  logic [W:0]    bqm;
  logic [W:0]    nq;
  logic [W:0]    nqm;

  assign in_rdy      = (state != OUT);
  assign busy        = (state == ACC);
  assign take        = ena & bus.in_vld & in_rdy;
  assign pos         = bus.d[1] & ~bus.d[0];
  assign neg         = bus.d[0] & ~bus.d[1];
  assign bus.in_rdy  = in_rdy;
  assign bus.out_vld = out_vld_q;
  assign bus.y       = y_q;

  // The first digit of a word starts from Q=0 / QM=-1; illegal 11 falls through as 0.
  always_comb begin
    bq  = (state == IDLE) ? '0 : q;
    bqm = (state == IDLE) ? '1 : qm;
    nq  = bq << 1;
    nqm = (bqm << 1) | ONE;
    if (pos) begin
      nq  = (bq << 1) | ONE;
      nqm = bq << 1;
    end else if (neg) begin
      nq  = (bqm << 1) | ONE;
      nqm = bqm << 1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      q         <= '0;
      qm        <= '1;
      y_q       <= '0;
      out_vld_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            q   <= nq;
            qm  <= nqm;
            cnt <= CW'(1);
            if (W == 1) begin
              y_q       <= nq;
              out_vld_q <= 1'b1;
              state     <= OUT;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (take) begin
            q   <= nq;
            qm  <= nqm;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
              y_q       <= nq;
              out_vld_q <= 1'b1;
              state     <= OUT;
            end
          end
        end
        OUT: begin
          if (ena && bus.out_rdy) begin
            out_vld_q <= 1'b0;
            cnt       <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OTF_CSD2BIN_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (take && (bus.d == 2'b11)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_otf_csd2bin.sv
// Self-checking bench for otf_csd2bin: directed words plus randomized words
// checked against an arithmetic digit-weighting model.
module tb_otf_csd2bin;
  localparam int W = 4;
  localparam int YMASK = (1 << (W + 1)) - 1;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] N = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] ILL = 2'b11;

  typedef logic [1:0] word_t [W];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic busy;
  logic err;
  bit   err_exp = 1'b0;
  int   check_count = 0;
  int   error_count = 0;

  otf_csd2bin_if #(.W(W)) bus ();

  otf_csd2bin #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Weighted sum of signed digits, MSB first; 11 weighs nothing.
  function automatic int ref_value(input word_t digs);
    int v = 0;
    for (int i = 0; i < W; i++) begin
      v = v * 2 + ((digs[i] == P) ? 1 : (digs[i] == N) ? -1 : 0);
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [1:0] dig);
    int budget = 0;
    @(negedge clk);
    bus.in_vld = 1'b1;
    bus.d      = dig;
    while (bus.in_rdy !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) checkOutput("accept_timeout", 32'(bus.in_rdy), 1);
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    bus.d      = Z;
`ifdef OTF_CSD2BIN_ERR_EN
    if (dig == ILL) err_exp = 1'b1;
`endif
  endtask

  task automatic run_word(input word_t digs, input int gap, input int hold, input bit drop_ena);
    int exp_y = ref_value(digs) & YMASK;
    bus.out_rdy = 1'b0;
    for (int i = 0; i < W; i++) begin
      repeat (gap) @(negedge clk);
      applyStimulus(digs[i]);
      if (i == 0) checkOutput("busy_acc", 32'(busy), 1);
      if (i == W - 2) checkOutput("early_vld", 32'(bus.out_vld), 0);
      if (i == 1 && drop_ena) begin
        @(negedge clk);
        ena        = 1'b0;
        bus.in_vld = 1'b1;
        bus.d      = P;
        repeat (3) begin
          @(negedge clk);
          checkOutput("ena_hold_busy", 32'(busy), 1);
          checkOutput("ena_hold_vld", 32'(bus.out_vld), 0);
        end
        ena        = 1'b1;
        bus.in_vld = 1'b0;
        bus.d      = Z;
      end
    end
    checkOutput("vld_on_last", 32'(bus.out_vld), 1);
    checkOutput("y", 32'(bus.y), exp_y);
    checkOutput("err", 32'(err), 32'(err_exp));
    repeat (hold) begin
      @(negedge clk);
      bus.in_vld = 1'b1;
      bus.d      = N;
      checkOutput("hold_rdy", 32'(bus.in_rdy), 0);
      checkOutput("hold_y", 32'(bus.y), exp_y);
      checkOutput("hold_vld", 32'(bus.out_vld), 1);
    end
    @(negedge clk);
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1;
    bus.d       = N;
    @(posedge clk);
    #1;
    bus.out_rdy = 1'b0;
    bus.in_vld  = 1'b0;
    bus.d       = Z;
    checkOutput("vld_clear", 32'(bus.out_vld), 0);
    checkOutput("rdy_back", 32'(bus.in_rdy), 1);
    checkOutput("busy_idle", 32'(busy), 0);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_vld"}, 32'(bus.out_vld), 0);
    checkOutput({tag, "_y"}, 32'(bus.y), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_err"}, 32'(err), 0);
    checkOutput({tag, "_rdy"}, 32'(bus.in_rdy), 1);
  endtask

  initial begin
    word_t w;
    bus.in_vld  = 1'b0;
    bus.d       = Z;
    bus.out_rdy = 1'b0;
    #2;
    check_reset_state("reset");
    #10;
    rst_n = 1'b1;

    w = '{P, Z, N, P};   run_word(w, 0, 0, 1'b0);
    w = '{N, N, N, N};   run_word(w, 0, 0, 1'b0);
    w = '{Z, Z, Z, Z};   run_word(w, 0, 0, 1'b0);
    w = '{P, N, Z, Z};   run_word(w, 0, 0, 1'b0);
    w = '{P, P, P, P};   run_word(w, 0, 5, 1'b0);
    w = '{P, Z, Z, N};   run_word(w, 2, 0, 1'b0);
    w = '{P, Z, Z, N};   run_word(w, 0, 0, 1'b1);

    // Reset in the middle of a word.
    applyStimulus(P);
    applyStimulus(P);
    #2;
    rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    check_reset_state("midword_rst");
    #3;
    rst_n = 1'b1;
    w = '{Z, Z, Z, P};   run_word(w, 0, 0, 1'b0);

    // Reset while a result is waiting.
    for (int i = 0; i < W; i++) applyStimulus(P);
    checkOutput("pre_rst_vld", 32'(bus.out_vld), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("outvld_rst");
    #3;
    rst_n = 1'b1;

    w = '{P, ILL, Z, Z}; run_word(w, 0, 0, 1'b0);
    w = '{P, Z, Z, Z};   run_word(w, 1, 1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      foreach (w[i]) w[i] = 2'($urandom_range(0, 3));
      run_word(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    rst_n = 1'b0;
    err_exp = 1'b0;
    #1;
    check_reset_state("final_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end
endmodule
